// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame geometry and the
// uart_ctrl register bit map used by both the RX and TX controllers.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam int RX_CONTAINS_DATA = 2;
    localparam int TX_SENDING       = 1;
    localparam int TX_EN            = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks
// (one oversample period). Shared by the receive and transmit paths.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_controller.sv
// 16x oversampled 8N1 UART receiver with a one-entry holding buffer,
// valid/ready delivery to the SD side and sticky framing/overrun flags.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       sd_rx_ready,
    input  logic       err_clear,
    output logic [7:0] sd_rx_data,
    output logic       sd_rx_valid,
    output logic       uart_ctrl_rx_flag,
    output logic       ctrl_reg_en,
    output logic       rx_reg_en,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam logic [3:0] SC_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SC_MID   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic       rx_meta;
    logic       rx_s;
    logic       tick;

    rx_state_t  state, state_nx;
    logic [3:0] sc, sc_nx;
    logic [2:0] bit_idx, bit_idx_nx;
    logic [7:0] shift, shift_nx;
    logic       stop_good;
    logic       stop_bad;

    logic       consume;
    logic       load;
    logic       overrun_set;
    logic       valid_nx;
    logic       frame_nx;
    logic       overrun_nx;
    logic       ctrl_pulse;

    // Synchronizers idle high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RX_IDLE;
            sc      <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            sc      <= sc_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sc_nx      = sc;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        if (tick) begin
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_nx = RX_START;
                        sc_nx    = '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid start bit means a glitch, not a frame.
                    if (sc == SC_MID) begin
                        if (rx_s) begin
                            state_nx = RX_IDLE;
                        end else begin
                            state_nx   = RX_DATA;
                            sc_nx      = '0;
                            bit_idx_nx = '0;
                        end
                    end else begin
                        sc_nx = sc + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (sc == SC_LAST) begin
                        shift_nx = {rx_s, shift[7:1]};
                        sc_nx    = '0;
                        if (bit_idx == BIT_LAST) begin
                            state_nx = RX_STOP;
                        end else begin
                            bit_idx_nx = bit_idx + 1'b1;
                        end
                    end else begin
                        sc_nx = sc + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (sc == SC_LAST) begin
                        stop_good = rx_s;
                        stop_bad  = !rx_s;
                        state_nx  = RX_IDLE;
                    end else begin
                        sc_nx = sc + 1'b1;
                    end
                end
                default: state_nx = RX_IDLE;
            endcase
        end
    end

    // A byte may load into a buffer that is being drained in the same cycle.
    assign consume     = sd_rx_valid & sd_rx_ready;
    assign load        = stop_good & (~sd_rx_valid | consume);
    assign overrun_set = stop_good & sd_rx_valid & ~consume;
    assign valid_nx    = load | (sd_rx_valid & ~consume);
    assign frame_nx    = stop_bad | (frame_err & ~err_clear);
    assign overrun_nx  = overrun_set | (overrun_err & ~err_clear);
    assign ctrl_pulse  = (valid_nx != sd_rx_valid)
                       | (stop_bad & ~frame_err)
                       | (overrun_set & ~overrun_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_rx_valid <= 1'b0;
            sd_rx_data  <= 8'h00;
            rx_reg_en   <= 1'b0;
            ctrl_reg_en <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sd_rx_valid <= valid_nx;
            if (load) begin
                sd_rx_data <= shift;
            end
            rx_reg_en   <= load;
            ctrl_reg_en <= ctrl_pulse;
            frame_err   <= frame_nx;
            overrun_err <= overrun_nx;
        end
    end

    assign uart_ctrl_rx_flag = sd_rx_valid;

endmodule
